// File: rtl/quad_shader_pipe.sv
// quad_shader_pipe: two-stage LANES-wide procedural pixel shader with valid/ready backpressure
module quad_shader_pipe #(
    parameter int BITS_X    = 9,
    parameter int BITS_Y    = 8,
    parameter int LANES     = 4,
    parameter int CW        = 8,
    parameter int CHK_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS_X-1:0]   px_x_base,
    input  logic [BITS_Y-1:0]   px_y,
    input  logic [1:0]          mode,
    input  logic [3*CW-1:0]     solid_rgb,
    input  logic                frame_tick,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LANES*CW-1:0] R_quad,
    output logic [LANES*CW-1:0] G_quad,
    output logic [LANES*CW-1:0] B_quad,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         beat_count
);
    localparam int XW = BITS_X + $clog2(LANES);
    localparam int MW = XW + BITS_Y + CW + 8;

    logic                v1_q, out_valid_q, adv;
    logic [BITS_X-1:0]   x1_q;
    logic [BITS_Y-1:0]   y1_q;
    logic [1:0]          m1_q;
    logic [3*CW-1:0]     rgb1_q;
    logic [7:0]          f1_q, frame_q;
    logic [15:0]         bc_q;
    logic [LANES*CW-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
    logic [MW-1:0]       yw, fw;

    assign adv        = !out_valid_q | out_ready;
    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign R_quad     = r_q;
    assign G_quad     = g_q;
    assign B_quad     = b_q;
    assign beat_count = bc_q;
    assign yw         = MW'(y1_q);
    assign fw         = MW'(f1_q);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [MW-1:0] xi;
        logic          c;
        assign xi = MW'(x1_q) + MW'(i);
        assign c  = xi[CHK_SHIFT] ^ y1_q[CHK_SHIFT];
        assign r_d[(LANES-1-i)*CW +: CW] = m1_q == 2'd0 ? CW'(xi >> 2) :
                                           m1_q == 2'd1 ? CW'(xi + fw) :
                                           m1_q == 2'd2 ? rgb1_q[3*CW-1:2*CW] : {CW{c}};
        assign g_d[(LANES-1-i)*CW +: CW] = m1_q == 2'd0 ? CW'(yw >> 1) :
                                           m1_q == 2'd1 ? CW'(yw + fw) :
                                           m1_q == 2'd2 ? rgb1_q[2*CW-1:CW] : {CW{c}};
        assign b_d[(LANES-1-i)*CW +: CW] = m1_q == 2'd0 ? CW'(xi ^ yw) :
                                           m1_q == 2'd1 ? CW'(xi ^ yw ^ fw) :
                                           m1_q == 2'd2 ? rgb1_q[CW-1:0] : {CW{c}};
    end

    // stage 1: capture the beat and the frame value seen at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            if (in_valid) begin
                x1_q   <= px_x_base;
                y1_q   <= px_y;
                m1_q   <= mode;
                rgb1_q <= solid_rgb;
                f1_q   <= frame_q;
            end
        end
    end

    // stage 2: register shaded lanes; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else if (adv) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                r_q <= r_d;
                g_q <= g_d;
                b_q <= b_d;
            end
        end
    end

    // frame counter runs regardless of stalls; beat counter counts output transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            bc_q    <= '0;
        end else begin
            frame_q <= frame_q + {7'd0, frame_tick};
            bc_q    <= bc_q + {15'd0, out_valid_q & out_ready};
        end
    end
endmodule
